// File: rtl/knn_sort_if.sv
// Pair stream from the distance unit into knn_sort: (squared distance, label)
// with a valid/ready handshake.
interface knn_sort_if #(
  parameter int W       = 32,
  parameter int LABEL_W = 8
);
  logic               dist_valid;
  logic               dist_ready;
  logic [W:0]         dist_in;
  logic [LABEL_W-1:0] label_in;

  modport master (
    output dist_valid,
    output dist_in,
    output label_in,
    input  dist_ready
  );

  modport slave (
    input  dist_valid,
    input  dist_in,
    input  label_in,
    output dist_ready
  );
endinterface

// File: rtl/knn_sort.sv
// Keeps the K smallest (distance, label) pairs in ascending order, one insert per 2 cycles.
// Optional macro KNN_SORT_DISCARD_CNT_EN adds a saturating discard counter output.
module knn_sort #(
  parameter int W       = 32,
  parameter int K       = 10,
  parameter int LABEL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  knn_sort_if.slave              dist_if,
  output logic                   busy,
  output logic [$clog2(K+1)-1:0] count,
  input  logic [$clog2(K)-1:0]   rd_addr,
  output logic [W:0]             rd_dist,
  output logic [LABEL_W-1:0]     rd_label,
  output logic                   rd_vld
`ifdef KNN_SORT_DISCARD_CNT_EN
  ,
  output logic [15:0]            discard_cnt
`endif
);
  localparam int CW = $clog2(K + 1);
  localparam int AW = $clog2(K);

  typedef enum logic {
    IDLE,
    INSERT
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic               ready_next;
  logic               transfer;
  logic               do_insert;
  logic               full;
  logic               any_gt;
  logic [CW-1:0]      count_reg;
  logic [W:0]         stage_dist_reg;
  logic [LABEL_W-1:0] stage_label_reg;

  logic [W:0]         slot_dist  [K];
  logic [LABEL_W-1:0] slot_label [K];
  logic [K-1:0]       slot_vld;
  logic [K-1:0]       gt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    transfer   = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = !clear;
        transfer   = dist_if.dist_valid && !clear;
        if (transfer) begin
          state_next = INSERT;
        end
      end
      INSERT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
    end
  end

  // The handshake is held off for as long as reset is asserted, without waiting for a clock.
  assign dist_if.dist_ready = ready_next && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_dist_reg  <= '0;
      stage_label_reg <= '0;
    end else if (transfer) begin
      stage_dist_reg  <= dist_if.dist_in;
      stage_label_reg <= dist_if.label_in;
    end
  end

  assign do_insert = (state_reg == INSERT) && !clear;
  assign full      = (count_reg == CW'(K));
  assign any_gt    = |gt;

  // The list is sorted and packed from slot 0, so gt is a thermometer: every slot from the
  // first greater one onward shifts down one place and that first slot takes the staged pair.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      logic [W:0]         dist_reg;
      logic [LABEL_W-1:0] label_reg;
      logic               valid_reg;
      logic [W:0]         prev_dist;
      logic [LABEL_W-1:0] prev_label;
      logic               take_prev;
      logic               take_stage;

      if (gi == 0) begin : g_head
        assign take_prev  = 1'b0;
        assign prev_dist  = '0;
        assign prev_label = '0;
      end else begin : g_body
        assign take_prev  = gt[gi-1];
        assign prev_dist  = slot_dist[gi-1];
        assign prev_label = slot_label[gi-1];
      end

      // Strict compare keeps equal distances in arrival order.
      assign gt[gi]     = valid_reg && (dist_reg > stage_dist_reg);
      assign take_stage = !take_prev &&
                          (gt[gi] || (!any_gt && !full && (count_reg == CW'(gi))));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dist_reg  <= '0;
          label_reg <= '0;
          valid_reg <= 1'b0;
        end else if (clear) begin
          valid_reg <= 1'b0;
        end else if (do_insert) begin
          if (take_prev) begin
            dist_reg  <= prev_dist;
            label_reg <= prev_label;
            valid_reg <= 1'b1;
          end else if (take_stage) begin
            dist_reg  <= stage_dist_reg;
            label_reg <= stage_label_reg;
            valid_reg <= 1'b1;
          end
        end
      end

      assign slot_dist[gi]  = dist_reg;
      assign slot_label[gi] = label_reg;
      assign slot_vld[gi]   = valid_reg;
    end
  endgenerate

  // Any insert into a non-full list adds an entry; a full list only reorders or discards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (do_insert && !full) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign count = count_reg;

`ifdef KNN_SORT_DISCARD_CNT_EN
  logic [15:0] discard_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard_cnt_reg <= '0;
    end else if (clear) begin
      discard_cnt_reg <= '0;
    end else if (do_insert && full && !any_gt && (discard_cnt_reg != 16'hFFFF)) begin
      discard_cnt_reg <= discard_cnt_reg + 16'd1;
    end
  end

  assign discard_cnt = discard_cnt_reg;
`endif

  // An address with no matching occupied slot, including any index >= K, reads as all zeros.
  always_comb begin
    rd_vld   = 1'b0;
    rd_dist  = '0;
    rd_label = '0;
    for (int i = 0; i < K; i++) begin
      if ((rd_addr == AW'(i)) && slot_vld[i]) begin
        rd_vld   = 1'b1;
        rd_dist  = slot_dist[i];
        rd_label = slot_label[i];
      end
    end
  end
endmodule

// File: tb/tb_knn_sort.sv
// Bench for knn_sort with K=4: stimulus table plus hand-written clear/reset/throughput
// sequences, with a sorted-list reference model and a count scoreboard.
module tb_knn_sort;
  localparam int W       = 32;
  localparam int K       = 4;
  localparam int LABEL_W = 8;
  localparam int CW      = $clog2(K + 1);
  localparam int AW      = $clog2(K);
  localparam int NVEC    = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic               busy;
  logic [CW-1:0]      count;
  logic [AW-1:0]      rd_addr = '0;
  logic [W:0]         rd_dist;
  logic [LABEL_W-1:0] rd_label;
  logic               rd_vld;
`ifdef KNN_SORT_DISCARD_CNT_EN
  logic [15:0]        discard_cnt;
`endif

  knn_sort_if #(.W(W), .LABEL_W(LABEL_W)) dif ();

  knn_sort #(.W(W), .K(K), .LABEL_W(LABEL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .dist_if  (dif),
    .busy     (busy),
    .count    (count),
    .rd_addr  (rd_addr),
    .rd_dist  (rd_dist),
    .rd_label (rd_label),
    .rd_vld   (rd_vld)
`ifdef KNN_SORT_DISCARD_CNT_EN
    ,
    .discard_cnt (discard_cnt)
`endif
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  // Reference model: ascending list, new pair goes after equal distances.
  logic [W:0]         md[$];
  logic [LABEL_W-1:0] ml[$];
  int                 mdisc = 0;
  int                 sb[$];

  function automatic void model_clear();
    md.delete();
    ml.delete();
    sb.delete();
    mdisc = 0;
  endfunction

  function automatic void model_insert(input logic [W:0] d, input logic [LABEL_W-1:0] l);
    int p;
    p = md.size();
    for (int i = 0; i < md.size(); i++) begin
      if (md[i] > d) begin
        p = i;
        break;
      end
    end
    if (p >= K) begin
      mdisc++;
    end else begin
      md.insert(p, d);
      ml.insert(p, l);
      if (md.size() > K) begin
        void'(md.pop_back());
        void'(ml.pop_back());
      end
    end
    sb.push_back(md.size());
  endfunction

  // Scoreboard: each completed insertion (busy falling) pops the expected occupancy.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    int e;
    if (busy_prev && !busy && rst && (sb.size() > 0)) begin
      e = sb.pop_front();
      check("sb_count", 64'(count), 64'(e));
    end
    busy_prev = busy;
  end

  task automatic send(input logic [W:0] d, input logic [LABEL_W-1:0] l, input bit track);
    int cyc;
    cyc = 0;
    dif.dist_valid = 1'b1;
    dif.dist_in    = d;
    dif.label_in   = l;
    forever begin
      @(negedge clk);
      if (dif.dist_ready) break;
      cyc++;
      if (cyc > 20) begin
        total++;
        bad++;
        $display("FAIL send_timeout: dist_ready=0 for 20 cycles, want 1");
        break;
      end
    end
    if (track) model_insert(d, l);
    $display("send dist=%0h label=%0d", d, l);
    @(posedge clk);
    #1;
    dif.dist_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_list();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic check_model(input string tag);
    for (int a = 0; a < K; a++) begin
      rd_addr = AW'(a);
      #1;
      if (a < md.size()) begin
        check($sformatf("%s_vld%0d", tag, a), 64'(rd_vld), 64'(1));
        check($sformatf("%s_dist%0d", tag, a), 64'(rd_dist), 64'(md[a]));
        check($sformatf("%s_label%0d", tag, a), 64'(rd_label), 64'(ml[a]));
      end else begin
        check($sformatf("%s_vld%0d", tag, a), 64'(rd_vld), 64'(0));
        check($sformatf("%s_dist%0d", tag, a), 64'(rd_dist), 64'(0));
        check($sformatf("%s_label%0d", tag, a), 64'(rd_label), 64'(0));
      end
    end
    check($sformatf("%s_count", tag), 64'(count), 64'(md.size()));
`ifdef KNN_SORT_DISCARD_CNT_EN
    check($sformatf("%s_discard", tag), 64'(discard_cnt), 64'(mdisc));
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int                            n;
    logic [0:5][W:0]               d;
    logic [0:5][LABEL_W-1:0]       l;
    logic [0:K-1][W:0]             ed;
    logic [0:K-1][LABEL_W-1:0]     el;
    int                            ec;
    int                            edisc;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic logic [0:5][W:0] d6(input logic [W:0] a0, a1, a2, a3, a4, a5);
    return {a0, a1, a2, a3, a4, a5};
  endfunction
  function automatic logic [0:5][LABEL_W-1:0] l6(input logic [LABEL_W-1:0] a0, a1, a2, a3, a4, a5);
    return {a0, a1, a2, a3, a4, a5};
  endfunction
  function automatic logic [0:K-1][W:0] d4(input logic [W:0] a0, a1, a2, a3);
    return {a0, a1, a2, a3};
  endfunction
  function automatic logic [0:K-1][LABEL_W-1:0] l4(input logic [LABEL_W-1:0] a0, a1, a2, a3);
    return {a0, a1, a2, a3};
  endfunction

  localparam logic [W:0] DMAX = 33'h1_FFFF_FFFF;

  bit rdy_log[10];
  bit bsy_log[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    int accepted;
    int idx;
    logic [W:0]         tp_d[5];
    logic [LABEL_W-1:0] tp_l[5];

    dif.dist_valid = 1'b0;
    dif.dist_in    = '0;
    dif.label_in   = '0;

    vecs[0] = '{n:3, d:d6(30, 10, 20, 0, 0, 0), l:l6(3, 1, 2, 0, 0, 0),
                ed:d4(10, 20, 30, 0), el:l4(1, 2, 3, 0), ec:3, edisc:0};
    vecs[1] = '{n:6, d:d6(50, 40, 30, 20, 60, 10), l:l6(5, 4, 3, 2, 6, 1),
                ed:d4(10, 20, 30, 40), el:l4(1, 2, 3, 4), ec:4, edisc:1};
    vecs[2] = '{n:2, d:d6(5, 5, 0, 0, 0, 0), l:l6(7, 9, 0, 0, 0, 0),
                ed:d4(5, 5, 0, 0), el:l4(7, 9, 0, 0), ec:2, edisc:0};
    vecs[3] = '{n:5, d:d6(5, 5, 5, 5, 5, 0), l:l6(1, 2, 3, 4, 5, 0),
                ed:d4(5, 5, 5, 5), el:l4(1, 2, 3, 4), ec:4, edisc:1};
    vecs[4] = '{n:2, d:d6(DMAX, 0, 0, 0, 0, 0), l:l6(1, 2, 0, 0, 0, 0),
                ed:d4(0, DMAX, 0, 0), el:l4(2, 1, 0, 0), ec:2, edisc:0};
    vecs[5] = '{n:5, d:d6(7, 3, 9, 1, 8, 0), l:l6(1, 2, 3, 4, 5, 0),
                ed:d4(1, 3, 7, 8), el:l4(4, 2, 1, 5), ec:4, edisc:0};

    // Reset state while rst is held low.
    #5;
    check("rst_count", 64'(count), 64'(0));
    check("rst_ready", 64'(dif.dist_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_vld", 64'(rd_vld), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(dif.dist_ready), 64'(1));

    // Table-driven lists.
    for (int v = 0; v < NVEC; v++) begin
      clear_list();
      for (int j = 0; j < vecs[v].n; j++) begin
        send(vecs[v].d[j], vecs[v].l[j], 1'b1);
      end
      settle();
      for (int a = 0; a < K; a++) begin
        rd_addr = AW'(a);
        #1;
        check($sformatf("vec%0d_vld%0d", v, a), 64'(rd_vld), 64'(a < vecs[v].ec));
        check($sformatf("vec%0d_dist%0d", v, a), 64'(rd_dist),
              (a < vecs[v].ec) ? 64'(vecs[v].ed[a]) : 64'(0));
        check($sformatf("vec%0d_label%0d", v, a), 64'(rd_label),
              (a < vecs[v].ec) ? 64'(vecs[v].el[a]) : 64'(0));
      end
      check($sformatf("vec%0d_count", v), 64'(count), 64'(vecs[v].ec));
`ifdef KNN_SORT_DISCARD_CNT_EN
      check($sformatf("vec%0d_discard", v), 64'(discard_cnt), 64'(vecs[v].edisc));
`endif
      @(posedge clk);
      #1;
      check_model($sformatf("vec%0d_model", v));
    end

    // dist_valid held high: one acceptance every other cycle.
    clear_list();
    tp_d = '{9, 2, 7, 4, 1};
    tp_l = '{1, 2, 3, 4, 5};
    accepted = 0;
    idx = 0;
    dif.dist_valid = 1'b1;
    dif.dist_in    = tp_d[0];
    dif.label_in   = tp_l[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy_log[c] = dif.dist_ready;
      bsy_log[c] = busy;
      if (dif.dist_ready && dif.dist_valid) begin
        accepted++;
        model_insert(dif.dist_in, dif.label_in);
        $display("stream accept cycle=%0d dist=%0h", c, dif.dist_in);
      end
      @(posedge clk);
      #1;
      if (rdy_log[c] && dif.dist_valid) begin
        idx++;
        if (idx < 5) begin
          dif.dist_in  = tp_d[idx];
          dif.label_in = tp_l[idx];
        end else begin
          dif.dist_valid = 1'b0;
        end
      end
    end
    dif.dist_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("tp_ready%0d", c), 64'(rdy_log[c]), 64'((c % 2) == 0));
      check($sformatf("tp_busy%0d", c), 64'(bsy_log[c]), 64'((c % 2) == 1));
    end
    check("tp_accepted", 64'(accepted), 64'(5));
    settle();
    check_model("tp");

    // clear during the INSERT of a pending 15.
    clear_list();
    send(12, 1, 1'b1);
    send(25, 2, 1'b1);
    settle();
    check_model("pre_clr");
    send(15, 3, 1'b0);
    check("clr_ins_busy", 64'(busy), 64'(1));
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    check_model("clr_ins");
    settle();
    check_model("clr_ins_late");

    // clear together with dist_valid in IDLE: no transfer.
    clear = 1'b1;
    dif.dist_valid = 1'b1;
    dif.dist_in    = 11;
    dif.label_in   = 4;
    @(negedge clk);
    check("clr_idle_ready", 64'(dif.dist_ready), 64'(0));
    @(posedge clk);
    #1;
    clear = 1'b0;
    dif.dist_valid = 1'b0;
    check("clr_idle_busy", 64'(busy), 64'(0));
    settle();
    check_model("clr_idle");

    // Asynchronous reset mid-stream.
    send(40, 1, 1'b1);
    send(20, 2, 1'b1);
    send(30, 3, 1'b1);
    settle();
    check_model("pre_rst");
    rd_addr = '0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'(0));
    check("arst_vld", 64'(rd_vld), 64'(0));
    check("arst_dist", 64'(rd_dist), 64'(0));
    check("arst_label", 64'(rd_label), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_ready", 64'(dif.dist_ready), 64'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(DMAX, 1, 1'b1);
    send(0, 2, 1'b1);
    settle();
    check_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
